// File: rtl/instr_rom_loadable_if.sv
// Load and fetch ports of the loadable instruction memory.
// master = core/loader side, slave = memory side.
interface instr_rom_loadable_if #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 16
);
    logic              ld_start;
    logic              ld_valid;
    logic [DATA_W-1:0] ld_data;
    logic              ld_last;
    logic              ld_ready;
    logic              ld_done;
    logic              ld_err;
    logic [ADDR_W:0]   prog_len;
    logic              fetch_req;
    logic [ADDR_W-1:0] fetch_addr;
    logic              fetch_ready;
    logic              instr_valid;
    logic [DATA_W-1:0] instr;

    modport master (
        output ld_start, ld_valid, ld_data, ld_last, fetch_req, fetch_addr,
        input  ld_ready, ld_done, ld_err, prog_len, fetch_ready, instr_valid, instr
    );

    modport slave (
        input  ld_start, ld_valid, ld_data, ld_last, fetch_req, fetch_addr,
        output ld_ready, ld_done, ld_err, prog_len, fetch_ready, instr_valid, instr
    );
endinterface

// File: rtl/instr_rom_loadable.sv
// Run-time loadable instruction memory: a loader FSM streams the program in,
// fetches get a registered read; anything past prog_len reads DEFAULT_INSTR.
module instr_rom_loadable #(
    parameter int                DATA_W        = 32,
    parameter int                ADDR_W        = 16,
    parameter int                DEPTH         = 64,
    parameter logic [DATA_W-1:0] DEFAULT_INSTR = DATA_W'(32'hD60003E0)
) (
    input  logic                 clk,
    input  logic                 rst_n,
    instr_rom_loadable_if.slave  bus
);
    localparam int              MW       = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [ADDR_W:0] LAST_IDX = (ADDR_W+1)'(DEPTH - 1);
    localparam logic [ADDR_W:0] ONE      = (ADDR_W+1)'(1);

    typedef enum logic [1:0] {IDLE, LOAD, RUN} state_t;

    state_t            state_q, state_d;
    logic [ADDR_W:0]   wptr_q, wptr_d;
    logic [ADDR_W:0]   plen_q, plen_d;
    logic              done_q, done_d;
    logic              err_q, err_d;
    logic              ivld_q, ivld_d;
    logic [DATA_W-1:0] instr_q, instr_d;

    logic              beat;
    logic              ld_rdy;
    logic              fetch_rdy;
    logic              fetch_acc;
    logic              fetch_hit;
    logic [DATA_W-1:0] rd_word;

    // Array is deliberately not cleared by reset; prog_len=0 masks stale words.
    logic [DATA_W-1:0] mem [DEPTH];

    always_comb begin
        state_d = state_q;
        wptr_d  = wptr_q;
        plen_d  = plen_q;
        done_d  = 1'b0;
        err_d   = 1'b0;
        beat    = 1'b0;
        ld_rdy  = (state_q == LOAD);
        unique case (state_q)
            IDLE, RUN: begin
                if (bus.ld_start) begin
                    state_d = LOAD;
                    wptr_d  = '0;
                    plen_d  = '0;
                end
            end
            LOAD: begin
                if (bus.ld_valid) begin
                    beat   = 1'b1;
                    wptr_d = wptr_q + ONE;
                    plen_d = wptr_q + ONE;
                    if (bus.ld_last) begin
                        state_d = RUN;
                        done_d  = 1'b1;
                    end else if (wptr_q == LAST_IDX) begin
                        // Storage full before ld_last: truncate and flag it.
                        state_d = RUN;
                        done_d  = 1'b1;
                        err_d   = 1'b1;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        fetch_rdy = (state_q != LOAD);
        fetch_acc = bus.fetch_req & fetch_rdy;
        // prog_len never exceeds DEPTH, so this also rejects addr >= DEPTH.
        fetch_hit = ({1'b0, bus.fetch_addr} < plen_q);
        rd_word   = mem[bus.fetch_addr[MW-1:0]];
        ivld_d    = fetch_acc;
        instr_d   = instr_q;
        if (fetch_acc) begin
            instr_d = fetch_hit ? rd_word : DEFAULT_INSTR;
        end
    end

    always_ff @(posedge clk) begin
        if (beat) begin
            mem[wptr_q[MW-1:0]] <= bus.ld_data;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            wptr_q  <= '0;
            plen_q  <= '0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
            ivld_q  <= 1'b0;
            instr_q <= DEFAULT_INSTR;
        end else begin
            state_q <= state_d;
            wptr_q  <= wptr_d;
            plen_q  <= plen_d;
            done_q  <= done_d;
            err_q   <= err_d;
            ivld_q  <= ivld_d;
            instr_q <= instr_d;
        end
    end

    assign bus.ld_ready    = ld_rdy;
    assign bus.ld_done     = done_q;
    assign bus.ld_err      = err_q;
    assign bus.prog_len    = plen_q;
    assign bus.fetch_ready = fetch_rdy;
    assign bus.instr_valid = ivld_q;
    assign bus.instr       = instr_q;
endmodule
